// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: shift mode codes and FSM state encodings.
package seq_shifter_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } sh_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-step shifter: shifts din by n places (0..STEP) in the selected mode
// and reports the last bit shifted out (or wrapped, for rotates).
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] n,
    input  logic [2:0]         mode,
    output logic [WIDTH-1:0]   dout,
    output logic               cout
);

    // Double-width working value: the half not returned catches the bits pushed out,
    // so the last bit out always sits right next to the result boundary.
    logic        [2*WIDTH-1:0] ext;
    logic signed [2*WIDTH-1:0] sext;

    always_comb begin
        ext  = '0;
        sext = '0;
        dout = din;
        cout = 1'b0;
        case (mode)
            SH_SRL: begin
                ext  = {din, {WIDTH{1'b0}}} >> n;
                dout = ext[2*WIDTH-1:WIDTH];
                cout = ext[WIDTH-1];
            end
            SH_SRA: begin
                sext = {din, {WIDTH{1'b0}}};
                ext  = sext >>> n;
                dout = ext[2*WIDTH-1:WIDTH];
                cout = ext[WIDTH-1];
            end
            SH_ROL: begin
                ext  = {din, din} << n;
                dout = ext[2*WIDTH-1:WIDTH];
                cout = (n != '0) & ext[WIDTH];
            end
            SH_ROR: begin
                ext  = {din, din} >> n;
                dout = ext[WIDTH-1:0];
                cout = (n != '0) & ext[WIDTH-1];
            end
            default: begin
                // SLL, and the unused codes 5-7 which behave as SLL
                ext  = {{WIDTH{1'b0}}, din} << n;
                dout = ext[WIDTH-1:0];
                cout = ext[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL/ROR by a run-time amount, up to STEP bits per
// clock, with a start/done handshake, carry (last bit out) and zero flag.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero
);

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [SHAMT_W-1:0] rem_reg, rem_next;
    logic [2:0]         mode_reg, mode_next;
    logic               cacc_reg, cacc_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               carry_reg, carry_next;
    logic               zero_reg, zero_next;

    logic [SHAMT_W-1:0] step_n;
    logic [WIDTH-1:0]   step_out;
    logic               step_cout;
    logic               accept;

    assign step_n = (rem_reg > STEP_AMT) ? STEP_AMT : rem_reg;
    assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign busy   = (state_reg == ST_SHIFT);
    assign done   = (state_reg == ST_DONE);
    assign accept = start && ready;
    assign result = result_reg;
    assign carry  = carry_reg;
    assign zero   = zero_reg;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .din  (acc_reg),
        .n    (step_n),
        .mode (mode_reg),
        .dout (step_out),
        .cout (step_cout)
    );

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        rem_next    = rem_reg;
        mode_next   = mode_reg;
        cacc_next   = cacc_reg;
        result_next = result_reg;
        carry_next  = carry_reg;
        zero_next   = zero_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                    acc_next   = din;
                    rem_next   = amt;
                    mode_next  = mode;
                    cacc_next  = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Visible outputs change only on the edge that enters DONE.
                if (rem_reg == '0) begin
                    state_next  = ST_DONE;
                    result_next = acc_reg;
                    carry_next  = cacc_reg;
                    zero_next   = (acc_reg == '0);
                end else begin
                    acc_next  = step_out;
                    cacc_next = step_cout;
                    rem_next  = rem_reg - step_n;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            rem_reg    <= '0;
            mode_reg   <= 3'd0;
            cacc_reg   <= 1'b0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            rem_reg    <= rem_next;
            mode_reg   <= mode_next;
            cacc_reg   <= cacc_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            zero_reg   <= zero_next;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=4 instance, expected results from
// a bit-serial reference model queued at start and popped when done is seen.
module tb_seq_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, b_start;
    logic [2:0]  a_mode, b_mode;
    logic [15:0] a_din, b_din;
    logic [3:0]  a_amt, b_amt;
    logic        a_ready, a_busy, a_done, a_carry, a_zero;
    logic        b_ready, b_busy, b_done, b_carry, b_zero;
    logic [15:0] a_result, b_result;

    seq_shifter #(.WIDTH(16), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .din(a_din), .amt(a_amt),
        .ready(a_ready), .busy(a_busy), .done(a_done), .result(a_result),
        .carry(a_carry), .zero(a_zero)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) dut_s4 (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .din(b_din), .amt(b_amt),
        .ready(b_ready), .busy(b_busy), .done(b_done), .result(b_result),
        .carry(b_carry), .zero(b_zero)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int accept_edge = 0;

    logic [15:0] q_res[$];
    logic        q_c[$];
    logic        q_z[$];
    int          q_lat[$];

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [2:0] m, input logic [15:0] d, input int a);
        logic [15:0] v;
        logic        c;
        v = d;
        c = 1'b0;
        for (int i = 0; i < a; i++) begin
            case (m)
                3'd1:    begin c = v[0];  v = {1'b0, v[15:1]};  end
                3'd2:    begin c = v[0];  v = {v[15], v[15:1]}; end
                3'd3:    begin c = v[15]; v = {v[14:0], v[15]}; end
                3'd4:    begin c = v[0];  v = {v[0], v[15:1]};  end
                default: begin c = v[15]; v = {v[14:0], 1'b0};  end
            endcase
        end
        return {c, v};
    endfunction

    task automatic push_exp(input logic [2:0] m, input logic [15:0] d, input int a, input int step);
        logic [16:0] r;
        r = model(m, d, a);
        q_res.push_back(r[15:0]);
        q_c.push_back(r[16]);
        q_z.push_back(r[15:0] == 16'h0);
        q_lat.push_back((a + step - 1) / step + 1);
    endtask

    task automatic get_out(input bit sel, output logic rdy, output logic bsy, output logic dn,
                           output logic [15:0] res, output logic c, output logic z);
        if (sel) begin
            rdy = b_ready; bsy = b_busy; dn = b_done; res = b_result; c = b_carry; z = b_zero;
        end else begin
            rdy = a_ready; bsy = a_busy; dn = a_done; res = a_result; c = a_carry; z = a_zero;
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [2:0] m,
                         input logic [15:0] d, input logic [3:0] a);
        if (sel) begin
            b_start = s; b_mode = m; b_din = d; b_amt = a;
        end else begin
            a_start = s; a_mode = m; a_din = d; a_amt = a;
        end
    endtask

    // Drives start for the accept edge; when hold is set, start stays high afterwards.
    task automatic start_op(input bit sel, input logic [2:0] m, input logic [15:0] d,
                            input logic [3:0] a, input bit hold, input bit expect_done);
        logic rdy, bsy, dn, c, z;
        logic [15:0] res;
        drive(sel, 1'b1, m, d, a);
        if (expect_done) push_exp(m, d, int'(a), sel ? 4 : 1);
        tick();
        accept_edge = edge_cnt;
        if (!hold) drive(sel, 1'b0, m, d, a);
        get_out(sel, rdy, bsy, dn, res, c, z);
        check("accept.busy", 32'(bsy), 32'd1);
        check("accept.done", 32'(dn), 32'd0);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        logic rdy, bsy, dn, c, z;
        logic [15:0] res;
        int i;
        dn = 1'b0;
        for (i = 0; i < 64; i++) begin
            get_out(sel, rdy, bsy, dn, res, c, z);
            if (dn) break;
            check({tag, ".busy"}, 32'(bsy), 32'd1);
            tick();
        end
        if (!dn) begin
            check({tag, ".done_timeout"}, 32'(dn), 32'd1);
            void'(q_res.pop_front()); void'(q_c.pop_front());
            void'(q_z.pop_front()); void'(q_lat.pop_front());
        end else begin
            check({tag, ".latency"}, 32'(edge_cnt - accept_edge), 32'(q_lat.pop_front()));
            check({tag, ".result"}, 32'(res), 32'(q_res.pop_front()));
            check({tag, ".carry"}, 32'(c), 32'(q_c.pop_front()));
            check({tag, ".zero"}, 32'(z), 32'(q_z.pop_front()));
            check({tag, ".ready"}, 32'(rdy), 32'd1);
            check({tag, ".busy_at_done"}, 32'(bsy), 32'd0);
        end
    endtask

    task automatic check_pulse_end(input bit sel, input string tag, input logic [15:0] held);
        logic rdy, bsy, dn, c, z;
        logic [15:0] res;
        tick();
        get_out(sel, rdy, bsy, dn, res, c, z);
        check({tag, ".done_low"}, 32'(dn), 32'd0);
        check({tag, ".held"}, 32'(res), 32'(held));
    endtask

    task automatic check_reset(input bit sel, input string tag);
        logic rdy, bsy, dn, c, z;
        logic [15:0] res;
        get_out(sel, rdy, bsy, dn, res, c, z);
        check({tag, ".ready"}, 32'(rdy), 32'd1);
        check({tag, ".busy"}, 32'(bsy), 32'd0);
        check({tag, ".done"}, 32'(dn), 32'd0);
        check({tag, ".result"}, 32'(res), 32'd0);
        check({tag, ".carry"}, 32'(c), 32'd0);
        check({tag, ".zero"}, 32'(z), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 4'd3);
        drive(1'b1, 1'b1, 3'd0, 16'hFFFF, 4'd3);
        tick();
        tick();
        check_reset(1'b0, "reset_s1");
        check_reset(1'b1, "reset_s4");
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0, 4'd0);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 4'd0);
        tick();

        // STEP=1: long SLL, then SRA/ROL/ROR
        start_op(1'b0, 3'd0, 16'h0001, 4'd15, 1'b0, 1'b1);
        wait_done(1'b0, "sll15");
        check_pulse_end(1'b0, "sll15", 16'h8000);
        start_op(1'b0, 3'd2, 16'h8000, 4'd4, 1'b0, 1'b1);
        wait_done(1'b0, "sra4");
        start_op(1'b0, 3'd3, 16'h8001, 4'd1, 1'b0, 1'b1);
        wait_done(1'b0, "rol1");
        start_op(1'b0, 3'd4, 16'h0001, 4'd1, 1'b0, 1'b1);
        wait_done(1'b0, "ror1");

        // STEP=4: partial final steps, amt=0, unused mode code
        start_op(1'b1, 3'd1, 16'hFFFF, 4'd7, 1'b0, 1'b1);
        wait_done(1'b1, "s4_srl7");
        start_op(1'b1, 3'd0, 16'h00F0, 4'd0, 1'b0, 1'b1);
        wait_done(1'b1, "s4_sll0");
        start_op(1'b1, 3'd7, 16'h0003, 4'd15, 1'b0, 1'b1);
        wait_done(1'b1, "s4_mode7");
        start_op(1'b1, 3'd4, 16'h1234, 4'd9, 1'b0, 1'b1);
        wait_done(1'b1, "s4_ror9");
        start_op(1'b1, 3'd2, 16'h8421, 4'd13, 1'b0, 1'b1);
        wait_done(1'b1, "s4_sra13");

        // amt=0 of zero data with start held: the DONE cycle accepts the next op
        start_op(1'b0, 3'd0, 16'h0000, 4'd0, 1'b1, 1'b0);
        push_exp(3'd0, 16'h0000, 0, 1);
        drive(1'b0, 1'b1, 3'd4, 16'h00A5, 4'd3);
        wait_done(1'b0, "b2b_a");
        push_exp(3'd4, 16'h00A5, 3, 1);
        tick();
        accept_edge = edge_cnt;
        drive(1'b0, 1'b0, 3'd0, 16'h0, 4'd0);
        check("b2b.done_low", 32'(a_done), 32'd0);
        check("b2b.busy", 32'(a_busy), 32'd1);
        wait_done(1'b0, "b2b_b");
        check_pulse_end(1'b0, "b2b_b", 16'hA014);

        // start pulse while busy must be ignored
        start_op(1'b0, 3'd1, 16'hF0F0, 4'd6, 1'b0, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b1, 3'd3, 16'h1234, 4'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 4'd0);
        wait_done(1'b0, "ignore");
        check_pulse_end(1'b0, "ignore", 16'h03C3);

        // reset mid-shift abandons the op
        start_op(1'b0, 3'd0, 16'h00FF, 4'd10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset(1'b0, "midrst");
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst.no_done", 32'(a_done), 32'd0);
        end
        start_op(1'b0, 3'd3, 16'h00FF, 4'd10, 1'b0, 1'b1);
        wait_done(1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
